// File: rtl/ivector_heard_serializer.sv
// ivector_heard_serializer
//   Accepts one IVector heard(meth, v) call at a time and streams it into the
//   host-bound indication pipe as a word sequence:
//     header  {message length in words [31:16], METHOD_ID [15:0]}
//     meth    NW words, least-significant word first
//     v       NW words, least-significant word first
//   where NW = DATA_WIDTH / WORD_WIDTH.
//
// Ports
//   CLK            clock, all state changes on posedge
//   nRST           synchronous active-low reset
//   heard__ENA     call strobe, honoured only while heard__RDY=1
//   heard_meth     meth argument (DATA_WIDTH)
//   heard_v        v argument (DATA_WIDTH)
//   heard__RDY     serializer idle and able to take a call
//   pipe_enq__ENA  pipe_enq_v carries a valid word
//   pipe_enq_v     outbound word (WORD_WIDTH)
//   pipe_enq__RDY  pipe takes the word on this edge
//   msg_count      messages fully sent since reset (wraps)
module ivector_heard_serializer #(
  parameter int          DATA_WIDTH = 128,
  parameter int          WORD_WIDTH = 32,
  parameter logic [15:0] METHOD_ID  = 16'h1
) (
  input  logic                  CLK,
  input  logic                  nRST,
  input  logic                  heard__ENA,
  input  logic [DATA_WIDTH-1:0] heard_meth,
  input  logic [DATA_WIDTH-1:0] heard_v,
  output logic                  heard__RDY,
  output logic                  pipe_enq__ENA,
  output logic [WORD_WIDTH-1:0] pipe_enq_v,
  input  logic                  pipe_enq__RDY,
  output logic [31:0]           msg_count
);

  localparam int                  NW        = DATA_WIDTH / WORD_WIDTH;
  localparam int                  IDX_W     = (NW > 1) ? $clog2(NW) : 1;
  localparam logic [IDX_W-1:0]    LAST_IDX  = IDX_W'(NW - 1);
  localparam logic [15:0]         MSG_WORDS = 16'(1 + 2 * NW);
  localparam logic [WORD_WIDTH-1:0] HDR_WORD = WORD_WIDTH'({MSG_WORDS, METHOD_ID});

  typedef enum logic [1:0] {
    S_IDLE,
    S_HDR,
    S_METH,
    S_VAL
  } state_t;

  state_t                state;
  state_t                state_nxt;
  logic [IDX_W-1:0]      idx;
  logic [DATA_WIDTH-1:0] meth_p0;
  logic [DATA_WIDTH-1:0] v_p0;
  logic                  last_word;

  function automatic logic [WORD_WIDTH-1:0] word_of(
    input logic [DATA_WIDTH-1:0] d,
    input logic [IDX_W-1:0]      i
  );
    return d[int'(i) * WORD_WIDTH +: WORD_WIDTH];
  endfunction

  assign last_word = (idx == LAST_IDX);

  // Outputs are a function of state/idx only, so a stalled word stays put
  // and there is no combinational path from pipe_enq__RDY.
  always_comb begin
    state_nxt     = state;
    heard__RDY    = 1'b0;
    pipe_enq__ENA = 1'b0;
    pipe_enq_v    = '0;
    case (state)
      S_IDLE: begin
        heard__RDY = 1'b1;
        if (heard__ENA) state_nxt = S_HDR;
      end
      S_HDR: begin
        pipe_enq__ENA = 1'b1;
        pipe_enq_v    = HDR_WORD;
        if (pipe_enq__RDY) state_nxt = S_METH;
      end
      S_METH: begin
        pipe_enq__ENA = 1'b1;
        pipe_enq_v    = word_of(meth_p0, idx);
        if (pipe_enq__RDY && last_word) state_nxt = S_VAL;
      end
      S_VAL: begin
        pipe_enq__ENA = 1'b1;
        pipe_enq_v    = word_of(v_p0, idx);
        if (pipe_enq__RDY && last_word) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Call capture / word stepping stage
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state     <= S_IDLE;
      idx       <= '0;
      meth_p0   <= '0;
      v_p0      <= '0;
      msg_count <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: begin
          if (heard__ENA) begin
            meth_p0 <= heard_meth;
            v_p0    <= heard_v;
            idx     <= '0;
          end
        end
        S_HDR: begin
          if (pipe_enq__RDY) idx <= '0;
        end
        S_METH, S_VAL: begin
          if (pipe_enq__RDY) begin
            idx <= last_word ? '0 : idx + IDX_W'(1);
            if (state == S_VAL && last_word) msg_count <= msg_count + 32'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ivector_heard_serializer.sv
// Testbench for ivector_heard_serializer: scenario tasks with a queue-based
// reference of the expected word stream and a negedge transfer monitor.
module tb_ivector_heard_serializer;

  localparam int DW   = 128;
  localparam int WW   = 32;
  localparam int NW   = DW / WW;
  localparam int MSGW = 1 + 2 * NW;

  logic          CLK = 1'b0;
  logic          nRST = 1'b0;
  logic          heard__ENA = 1'b0;
  logic [DW-1:0] heard_meth = '0;
  logic [DW-1:0] heard_v = '0;
  logic          heard__RDY;
  logic          pipe_enq__ENA;
  logic [WW-1:0] pipe_enq_v;
  logic          pipe_enq__RDY = 1'b1;
  logic [31:0]   msg_count;

  ivector_heard_serializer #(
    .DATA_WIDTH(DW),
    .WORD_WIDTH(WW),
    .METHOD_ID (16'h1)
  ) dut (
    .CLK          (CLK),
    .nRST         (nRST),
    .heard__ENA   (heard__ENA),
    .heard_meth   (heard_meth),
    .heard_v      (heard_v),
    .heard__RDY   (heard__RDY),
    .pipe_enq__ENA(pipe_enq__ENA),
    .pipe_enq_v   (pipe_enq_v),
    .pipe_enq__RDY(pipe_enq__RDY),
    .msg_count    (msg_count)
  );

  always #5 CLK = ~CLK;

  // Transfer monitor: a word sampled with ENA && RDY at the negedge moves on
  // the following posedge (inputs only change just after posedges).
  int          cyc = 0;
  logic [31:0] got[$];
  int          got_cyc[$];
  always @(negedge CLK) begin
    cyc <= cyc + 1;
    if (pipe_enq__ENA && pipe_enq__RDY) begin
      got.push_back(pipe_enq_v);
      got_cyc.push_back(cyc + 1);
    end
  end

  int          n_pass = 0;
  int          n_tot  = 0;
  logic [31:0] exp_count = '0;
  logic [31:0] exp_q[$];

  // Reference: header word, then meth words LSW first, then v words LSW first
  task automatic mk_exp(input logic [DW-1:0] m, input logic [DW-1:0] v);
    exp_q.push_back(32'h0009_0001);
    for (int k = 0; k < NW; k++) exp_q.push_back(m[k*WW +: WW]);
    for (int k = 0; k < NW; k++) exp_q.push_back(v[k*WW +: WW]);
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Raise ENA with data until the DUT is seen ready; returns header cycle.
  task automatic send_call(input logic [DW-1:0] m, input logic [DW-1:0] v, output int hdr_cyc);
    bit ok;
    ok         = 1'b0;
    hdr_cyc    = -1;
    heard_meth = m;
    heard_v    = v;
    heard__ENA = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge CLK);
      #1;
      if (heard__RDY) begin
        hdr_cyc = cyc + 1;
        ok      = 1'b1;
        break;
      end
    end
    @(posedge CLK);
    #1;
    heard__ENA = 1'b0;
    if (!ok) begin
      n_tot++;
      $display("FAIL send_call_timeout: heard__RDY=%0b required 1", heard__RDY);
    end
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge CLK);
      if (heard__RDY && !pipe_enq__ENA) begin
        ok = 1'b1;
        break;
      end
    end
    step();
    if (!ok) begin
      n_tot++;
      $display("FAIL idle_timeout: pipe_enq__ENA=%0b required 0", pipe_enq__ENA);
    end
  endtask

  task automatic test_reset();
    nRST = 1'b0;
    step();
    step();
    @(negedge CLK);
    n_tot++; if (heard__RDY !== 1'b1) $display("FAIL reset_rdy: got %0b want 1", heard__RDY); else n_pass++;
    n_tot++; if (pipe_enq__ENA !== 1'b0) $display("FAIL reset_ena: got %0b want 0", pipe_enq__ENA); else n_pass++;
    n_tot++; if (pipe_enq_v !== 32'h0) $display("FAIL reset_v: got %h want 0", pipe_enq_v); else n_pass++;
    n_tot++; if (msg_count !== 32'h0) $display("FAIL reset_count: got %0d want 0", msg_count); else n_pass++;
    step();
    nRST = 1'b1;
    step();
    exp_count = '0;
  endtask

  task automatic test_single();
    logic [DW-1:0] m, v;
    int base, h;
    m = {32'd4, 32'd3, 32'd2, 32'd1};
    v = {32'd8, 32'd7, 32'd6, 32'd5};
    pipe_enq__RDY = 1'b1;
    exp_q.delete();
    mk_exp(m, v);
    base = got.size();
    send_call(m, v, h);
    wait_idle();
    exp_count = exp_count + 1;
    n_tot++; if (got.size() - base !== MSGW) $display("FAIL single_len: got %0d want %0d", got.size() - base, MSGW); else n_pass++;
    for (int k = 0; k < MSGW && base + k < got.size(); k++) begin
      n_tot++; if (got[base+k] !== exp_q[k]) $display("FAIL single_word%0d: got %h want %h", k, got[base+k], exp_q[k]); else n_pass++;
      n_tot++; if (got_cyc[base+k] !== h + k) $display("FAIL single_cyc%0d: got %0d want %0d", k, got_cyc[base+k], h + k); else n_pass++;
    end
    n_tot++; if (msg_count !== exp_count) $display("FAIL single_count: got %0d want %0d", msg_count, exp_count); else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] m, v;
    int base, h;
    m = {32'd4, 32'd3, 32'd2, 32'd1};
    v = {32'd8, 32'd7, 32'd6, 32'd5};
    pipe_enq__RDY = 1'b1;
    exp_q.delete();
    mk_exp(m, v);
    base = got.size();
    send_call(m, v, h);
    step();
    step();
    pipe_enq__RDY = 1'b0;
    for (int s = 0; s < 3; s++) begin
      @(negedge CLK);
      n_tot++; if (pipe_enq_v !== 32'h2 || pipe_enq__ENA !== 1'b1)
        $display("FAIL stall_hold%0d: got ena=%0b v=%h want ena=1 v=00000002", s, pipe_enq__ENA, pipe_enq_v);
      else n_pass++;
      step();
    end
    pipe_enq__RDY = 1'b1;
    wait_idle();
    exp_count = exp_count + 1;
    n_tot++; if (got.size() - base !== MSGW) $display("FAIL bp_len: got %0d want %0d", got.size() - base, MSGW); else n_pass++;
    for (int k = 0; k < MSGW && base + k < got.size(); k++) begin
      n_tot++; if (got[base+k] !== exp_q[k]) $display("FAIL bp_word%0d: got %h want %h", k, got[base+k], exp_q[k]); else n_pass++;
    end
    if (base + 2 < got.size()) begin
      n_tot++; if (got_cyc[base+2] !== h + 5) $display("FAIL bp_stall_cyc: got %0d want %0d", got_cyc[base+2], h + 5); else n_pass++;
    end
    n_tot++; if (msg_count !== exp_count) $display("FAIL bp_count: got %0d want %0d", msg_count, exp_count); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] m1, v1, m2, v2;
    int base, h1, h2;
    m1 = {$urandom, $urandom, $urandom, $urandom};
    v1 = {$urandom, $urandom, $urandom, $urandom};
    m2 = {$urandom, $urandom, $urandom, $urandom};
    v2 = {$urandom, $urandom, $urandom, $urandom};
    pipe_enq__RDY = 1'b1;
    exp_q.delete();
    mk_exp(m1, v1);
    mk_exp(m2, v2);
    base = got.size();
    send_call(m1, v1, h1);
    send_call(m2, v2, h2);
    wait_idle();
    exp_count = exp_count + 2;
    n_tot++; if (got.size() - base !== 2 * MSGW) $display("FAIL b2b_len: got %0d want %0d", got.size() - base, 2 * MSGW); else n_pass++;
    for (int k = 0; k < 2 * MSGW && base + k < got.size(); k++) begin
      n_tot++; if (got[base+k] !== exp_q[k]) $display("FAIL b2b_word%0d: got %h want %h", k, got[base+k], exp_q[k]); else n_pass++;
    end
    n_tot++; if (h2 - h1 !== MSGW + 1) $display("FAIL b2b_gap: got %0d want %0d", h2 - h1, MSGW + 1); else n_pass++;
    n_tot++; if (msg_count !== exp_count) $display("FAIL b2b_count: got %0d want %0d", msg_count, exp_count); else n_pass++;
  endtask

  task automatic test_ignored_call();
    logic [DW-1:0] m, v;
    int base, h;
    m = {$urandom, $urandom, $urandom, $urandom};
    v = {$urandom, $urandom, $urandom, $urandom};
    pipe_enq__RDY = 1'b1;
    exp_q.delete();
    mk_exp(m, v);
    base = got.size();
    send_call(m, v, h);
    step(); step(); step();
    heard_meth = ~m;
    heard_v    = ~v;
    heard__ENA = 1'b1;
    step();
    heard__ENA = 1'b0;
    step(); step(); step(); step();
    // Pulse on the final VAL transfer edge as well
    heard__ENA = 1'b1;
    step();
    heard__ENA = 1'b0;
    wait_idle();
    step(); step(); step();
    exp_count = exp_count + 1;
    n_tot++; if (got.size() - base !== MSGW) $display("FAIL ign_len: got %0d want %0d", got.size() - base, MSGW); else n_pass++;
    for (int k = 0; k < MSGW && base + k < got.size(); k++) begin
      n_tot++; if (got[base+k] !== exp_q[k]) $display("FAIL ign_word%0d: got %h want %h", k, got[base+k], exp_q[k]); else n_pass++;
    end
    n_tot++; if (msg_count !== exp_count) $display("FAIL ign_count: got %0d want %0d", msg_count, exp_count); else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] m, v;
    int base, h;
    m = {32'd4, 32'd3, 32'd2, 32'd1};
    v = {32'd8, 32'd7, 32'd6, 32'd5};
    pipe_enq__RDY = 1'b1;
    exp_q.delete();
    mk_exp(m, v);
    base = got.size();
    send_call(m, v, h);
    step(); step(); step(); step(); step();
    nRST = 1'b0;
    step();
    nRST = 1'b1;
    exp_count = '0;
    @(negedge CLK);
    n_tot++; if (pipe_enq__ENA !== 1'b0) $display("FAIL rmid_ena: got %0b want 0", pipe_enq__ENA); else n_pass++;
    n_tot++; if (heard__RDY !== 1'b1) $display("FAIL rmid_rdy: got %0b want 1", heard__RDY); else n_pass++;
    n_tot++; if (msg_count !== exp_count) $display("FAIL rmid_count: got %0d want 0", msg_count); else n_pass++;
    for (int k = 0; k < 5 && base + k < got.size(); k++) begin
      n_tot++; if (got[base+k] !== exp_q[k]) $display("FAIL rmid_pre%0d: got %h want %h", k, got[base+k], exp_q[k]); else n_pass++;
    end
    step();
    base = got.size();
    send_call(m, v, h);
    wait_idle();
    exp_count = exp_count + 1;
    n_tot++; if (got.size() - base !== MSGW) $display("FAIL rmid_len: got %0d want %0d", got.size() - base, MSGW); else n_pass++;
    for (int k = 0; k < MSGW && base + k < got.size(); k++) begin
      n_tot++; if (got[base+k] !== exp_q[k]) $display("FAIL rmid_word%0d: got %h want %h", k, got[base+k], exp_q[k]); else n_pass++;
    end
    n_tot++; if (msg_count !== exp_count) $display("FAIL rmid_count2: got %0d want %0d", msg_count, exp_count); else n_pass++;
  endtask

  task automatic test_random_backpressure();
    logic [DW-1:0] m, v;
    logic [31:0]   prev_v;
    bit            prev_stall;
    int            base, h;
    for (int n = 0; n < 4; n++) begin
      m = {$urandom, $urandom, $urandom, $urandom};
      v = {$urandom, $urandom, $urandom, $urandom};
      pipe_enq__RDY = 1'b1;
      exp_q.delete();
      mk_exp(m, v);
      base = got.size();
      send_call(m, v, h);
      prev_stall = 1'b0;
      prev_v     = '0;
      for (int i = 0; i < 300; i++) begin
        pipe_enq__RDY = 1'($urandom_range(0, 1));
        @(negedge CLK);
        if (heard__RDY && !pipe_enq__ENA) break;
        if (prev_stall) begin
          n_tot++; if (pipe_enq_v !== prev_v) $display("FAIL rnd_hold: got %h want %h", pipe_enq_v, prev_v); else n_pass++;
        end
        prev_stall = pipe_enq__ENA && !pipe_enq__RDY;
        prev_v     = pipe_enq_v;
        step();
      end
      pipe_enq__RDY = 1'b1;
      wait_idle();
      exp_count = exp_count + 1;
      n_tot++; if (got.size() - base !== MSGW) $display("FAIL rnd_len: got %0d want %0d", got.size() - base, MSGW); else n_pass++;
      for (int k = 0; k < MSGW && base + k < got.size(); k++) begin
        n_tot++; if (got[base+k] !== exp_q[k]) $display("FAIL rnd_word%0d: got %h want %h", k, got[base+k], exp_q[k]); else n_pass++;
      end
      n_tot++; if (msg_count !== exp_count) $display("FAIL rnd_count: got %0d want %0d", msg_count, exp_count); else n_pass++;
    end
  endtask

  task automatic test_wrap();
    logic [DW-1:0] m, v;
    int h;
    m = {$urandom, $urandom, $urandom, $urandom};
    v = {$urandom, $urandom, $urandom, $urandom};
    pipe_enq__RDY = 1'b1;
    @(negedge CLK);
    force dut.msg_count = 32'hFFFF_FFFF;
    step();
    @(negedge CLK);
    release dut.msg_count;
    step();
    exp_count = 32'hFFFF_FFFF;
    @(negedge CLK);
    n_tot++; if (msg_count !== exp_count) $display("FAIL wrap_preset: got %h want %h", msg_count, exp_count); else n_pass++;
    step();
    send_call(m, v, h);
    wait_idle();
    exp_count = exp_count + 1;
    n_tot++; if (msg_count !== exp_count) $display("FAIL wrap_count: got %h want %h", msg_count, exp_count); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_back_to_back();
    test_ignored_call();
    test_reset_mid();
    test_random_backpressure();
    test_wrap();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d/%0d", n_pass, n_tot);
    $fatal(1);
  end

endmodule
